cordic_sched: RTL

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cordic_sched.sv
// cordic_sched
//   Shares one pipelined cordic core between NUM_REQ requesters.
//   A round-robin arbiter picks one valid requester per cycle (while fewer
//   than MAX_OUT results are outstanding) and issues its word to the cordic
//   one cycle later. The requester index travels through a tag FIFO in issue
//   order. Each cordic result is paired with its tag in a show-ahead result
//   FIFO until the consumer takes it.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_vld/i_req_data      per-requester request valid and packed words
//   o_req_rdy                 one-hot (or zero) grant
//   o_cor_vld/o_cor_data      issue toward the cordic (registered)
//   i_cor_vld/i_cor_data      results from the cordic, in issue order
//   o_res_vld/o_res_data/o_res_tag/i_res_rdy   result stream with owner tag
//   o_credit_cnt              results issued but not yet consumed
//   o_err                     sticky: cordic result with no matching issue
module cordic_sched #(
    parameter int NUM_REQ     = 4,
    parameter int TOTAL_WIDTH = 49,
    parameter int MAX_OUT     = 8,
    parameter int TAG_W       = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req_vld,
    input  logic [NUM_REQ*TOTAL_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]             o_req_rdy,
    output logic                           o_cor_vld,
    output logic [TOTAL_WIDTH-1:0]         o_cor_data,
    input  logic                           i_cor_vld,
    input  logic [TOTAL_WIDTH-1:0]         i_cor_data,
    output logic                           o_res_vld,
    output logic [TOTAL_WIDTH-1:0]         o_res_data,
    output logic [TAG_W-1:0]               o_res_tag,
    input  logic                           i_res_rdy,
    output logic [$clog2(MAX_OUT):0]       o_credit_cnt,
    output logic                           o_err
);

    localparam int AW = $clog2(MAX_OUT);
    localparam int CW = AW + 1;
    localparam int RW = TAG_W + TOTAL_WIDTH;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Unpack the request bus into one word per requester
    logic [TOTAL_WIDTH-1:0] req_word [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_word[gi] = i_req_data[gi*TOTAL_WIDTH +: TOTAL_WIDTH];
        end
    endgenerate

    logic [TAG_W-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]          credit_q, credit_d;
    logic                   cor_vld_q;
    logic [TOTAL_WIDTH-1:0] cor_data_q;
    logic                   err_q;

    logic [NUM_REQ-1:0]     gnt;
    logic [TAG_W-1:0]       gnt_idx;
    logic [TOTAL_WIDTH-1:0] gnt_data;
    logic                   gnt_found;
    int                     cand;

    // Round-robin search starting at ptr_q (one past the last grant).
    // No grant at all once MAX_OUT results are outstanding.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_data  = '0;
        gnt_found = 1'b0;
        cand      = 0;
        if (credit_q < CW'(MAX_OUT)) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = int'(ptr_q) + i;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                if (!gnt_found && i_req_vld[cand]) begin
                    gnt_found = 1'b1;
                    gnt[cand] = 1'b1;
                    gnt_idx   = TAG_W'(cand);
                    gnt_data  = req_word[cand];
                end
            end
        end
    end

    logic accept;
    assign accept    = gnt_found;
    assign o_req_rdy = gnt;

    // Pointer moves only on an accepted transfer
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == TAG_W'(NUM_REQ-1)) ? '0 : gnt_idx + TAG_W'(1);
        end
    end

    // Tag FIFO: requester index per issued word, in issue order
    logic [TAG_W-1:0] tag_mem [MAX_OUT];
    logic [AW:0]      tag_wr_q, tag_rd_q;
    logic             tag_empty, tag_pop;
    logic [TAG_W-1:0] tag_head;

    assign tag_empty = (tag_wr_q == tag_rd_q);
    assign tag_pop   = i_cor_vld && !tag_empty;
    assign tag_head  = tag_mem[tag_rd_q[AW-1:0]];

    // Result FIFO: {tag, cordic word}, show-ahead head
    logic [RW-1:0] res_mem [MAX_OUT];
    logic [AW:0]   res_wr_q, res_rd_q;
    logic          res_empty, res_pop;
    logic [RW-1:0] res_head;

    assign res_empty = (res_wr_q == res_rd_q);
    assign res_pop   = !res_empty && i_res_rdy;
    assign res_head  = res_mem[res_rd_q[AW-1:0]];

    // Credit: +1 per accept, -1 per consumed result
    always_comb begin
        credit_d = credit_q;
        if (accept && !res_pop)      credit_d = credit_q + CW'(1);
        else if (!accept && res_pop) credit_d = credit_q - CW'(1);
    end

    // Storage arrays carry no reset; only the pointers define contents
    always_ff @(posedge i_clk) begin
        if (accept)  tag_mem[tag_wr_q[AW-1:0]] <= gnt_idx;
        if (tag_pop) res_mem[res_wr_q[AW-1:0]] <= {tag_head, i_cor_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q      <= '0;
            credit_q   <= '0;
            cor_vld_q  <= 1'b0;
            cor_data_q <= '0;
            err_q      <= 1'b0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            res_wr_q   <= '0;
            res_rd_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            credit_q  <= credit_d;
            cor_vld_q <= accept;
            if (accept) cor_data_q <= gnt_data;
            // A result with no outstanding tag is dropped and flagged
            if (i_cor_vld && tag_empty) err_q <= 1'b1;
            if (accept)  tag_wr_q <= tag_wr_q + PTR_ONE;
            if (tag_pop) begin
                tag_rd_q <= tag_rd_q + PTR_ONE;
                res_wr_q <= res_wr_q + PTR_ONE;
            end
            if (res_pop) res_rd_q <= res_rd_q + PTR_ONE;
        end
    end

    assign o_cor_vld    = cor_vld_q;
    assign o_cor_data   = cor_data_q;
    assign o_res_vld    = !res_empty;
    assign o_res_data   = res_head[TOTAL_WIDTH-1:0];
    assign o_res_tag    = res_head[RW-1:TOTAL_WIDTH];
    assign o_credit_cnt = credit_q;
    assign o_err        = err_q;

endmodule
